uart_stream_link: RTL and testbench

// - Full-duplex UART endpoint with valid/ready streams on the parallel side; moves one DATA_WIDTH-bit word per serial frame.
// - Bridges the system bus to an off-chip or peer serial link.
// - Frame-compatible with the bus-side uart block: both use the same frame, bit order and bit period.

---
 rtl/uart_stream_link.sv | 202 ++++++++++++++++++++
 tb/tb_uart_stream_link.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_link.sv
// uart_stream_link: full-duplex UART endpoint with valid/ready streams on the parallel side.
// One DATA_WIDTH-bit word per frame: start bit (0), data LSB first, stop bit (1), each bit
// lasting CLK_FREQ/BAUD_RATE clocks.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rstn      synchronous reset, active-high (1 = reset)
//   sig_rx    serial receive line, idle high, asynchronous to clk
//   data_rx   last received word, stable while valid_rx is high
//   valid_rx  data_rx holds an unconsumed word
//   ready_rx  consumer accepts data_rx
//   sig_tx    serial transmit line, idle high
//   data_tx   word to transmit
//   valid_tx  data_tx is offered
//   ready_tx  transmitter idle and able to accept a word
module uart_stream_link #(
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig_rx,
  output logic [DATA_WIDTH-1:0] data_rx,
  output logic                  valid_rx,
  input  logic                  ready_rx,
  output logic                  sig_tx,
  input  logic [DATA_WIDTH-1:0] data_tx,
  input  logic                  valid_tx,
  output logic                  ready_tx
);

  localparam int unsigned BitClks  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HalfClks = BitClks / 2;
  localparam int unsigned CntW     = (BitClks > 1) ? $clog2(BitClks) : 1;
  localparam int unsigned IdxW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(BitClks - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfClks - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------------------------
  state_e                tx_state_q, tx_state_d;
  logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [IdxW-1:0]       tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitLast);

  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CntW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        // ready_tx is high in idle, so valid_tx alone completes the handshake
        if (valid_tx) begin
          tx_shift_d = data_tx;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_bit_end) tx_state_d = StData;
      end
      StData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == IdxLast) tx_state_d = StStop;
          else                     tx_idx_d   = tx_idx_q + IdxW'(1);
        end
      end
      StStop: begin
        if (tx_bit_end) tx_state_d = StIdle;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    sig_tx   = 1'b1;
    ready_tx = 1'b0;
    unique case (tx_state_q)
      StIdle:  ready_tx = 1'b1;
      StStart: sig_tx   = 1'b0;
      StData:  sig_tx   = tx_shift_q[0];
      StStop:  sig_tx   = 1'b1;
      default: sig_tx   = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------------
  logic [1:0]            rx_sync_q;
  logic                  rx_line;
  state_e                rx_state_q, rx_state_d;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [IdxW-1:0]       rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_bit_end;

  assign rx_line    = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == BitLast);

  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], sig_rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_valid_q && ready_rx) rx_valid_d = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_line) begin
          rx_state_d = StStart;
          // Dropping valid on every start gives each word its own valid rising edge
          rx_valid_d = 1'b0;
        end
      end
      StStart: begin
        // Re-check the line at mid start bit to reject glitches
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_line ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[DATA_WIDTH-1:1]};
          if (rx_idx_q == IdxLast) rx_state_d = StStop;
          else                     rx_idx_d   = rx_idx_q + IdxW'(1);
        end
      end
      StStop: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          // A low stop bit is a framing error: the word is dropped silently
          if (rx_line) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_comb begin
    data_rx  = rx_data_q;
    valid_rx = rx_valid_q;
  end

endmodule

// File: tb/tb_uart_stream_link.sv
// tb_uart_stream_link: scoreboard bench for uart_stream_link. Transmitted words are pushed into
// expected queues; a serial decoder on sig_tx and a valid_rx monitor pop and compare them.
// Uses a short bit period (16 clocks) so whole frames simulate quickly.
module tb_uart_stream_link;

  localparam int unsigned DW      = 25;
  localparam int unsigned BIT     = 16;
  localparam int unsigned FRAME   = (DW + 2) * BIT;
  localparam int          TIMEOUT = 4 * FRAME;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sig_rx;
  logic [DW-1:0] data_rx;
  logic          valid_rx;
  logic          ready_rx;
  logic          sig_tx;
  logic [DW-1:0] data_tx;
  logic          valid_tx;
  logic          ready_tx;

  logic loop_en;
  logic rx_drv;
  logic mon_en;

  assign sig_rx = loop_en ? sig_tx : rx_drv;

  uart_stream_link #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (1),
    .CLK_FREQ   (BIT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sig_rx   (sig_rx),
    .data_rx  (data_rx),
    .valid_rx (valid_rx),
    .ready_rx (ready_rx),
    .sig_tx   (sig_tx),
    .data_tx  (data_tx),
    .valid_tx (valid_tx),
    .ready_tx (ready_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tx_frames = 0;
  int rx_words = 0;
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial decoder: checks every clock of every bit against the expected frame
  initial begin : tx_monitor
    logic [DW-1:0] w;
    logic [DW-1:0] obs;
    logic          eb;
    int            glitches;
    forever begin
      @(negedge clk);
      if (mon_en && sig_tx === 1'b0) begin
        check_eq("tx_expected", tx_q.size() != 0, 1);
        w = (tx_q.size() != 0) ? tx_q.pop_front() : '0;
        obs = '0;
        glitches = 0;
        for (int b = 0; b < DW + 2; b++) begin
          if (b == 0)           eb = 1'b0;
          else if (b == DW + 1) eb = 1'b1;
          else                  eb = w[b-1];
          for (int j = 0; j < BIT; j++) begin
            if (sig_tx !== eb) glitches++;
            if (j == BIT / 2 && b >= 1 && b <= DW) obs[b-1] = sig_tx;
            if (!(b == DW + 1 && j == BIT - 1)) @(negedge clk);
          end
        end
        check_eq("tx_word", obs, w);
        check_eq("tx_shape", glitches, 0);
        tx_frames++;
      end
    end
  end

  logic rx_prev = 1'b0;
  initial begin : rx_monitor
    logic [DW-1:0] exp;
    forever begin
      @(negedge clk);
      if (valid_rx === 1'b1 && !rx_prev) begin
        check_eq("rx_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          exp = rx_q.pop_front();
          check_eq("rx_word", data_rx, exp);
        end
        rx_words++;
      end
      rx_prev = valid_rx;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready_tx !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_ready_wait", n < TIMEOUT, 1);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic to_rx);
    wait_ready();
    tx_q.push_back(w);
    if (to_rx) rx_q.push_back(w);
    valid_tx = 1'b1;
    data_tx  = w;
    @(negedge clk);
    valid_tx = 1'b0;
    data_tx  = '0;
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_words < target && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_count", rx_words, target);
  endtask

  task automatic drive_frame(input logic [DW-1:0] w, input logic stop_val, input int stop_len);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int b = 0; b < DW; b++) begin
      rx_drv = w[b];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (stop_len) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin : main
    int n;
    rstn     = 1'b1;
    ready_rx = 1'b0;
    data_tx  = '0;
    valid_tx = 1'b0;
    loop_en  = 1'b0;
    rx_drv   = 1'b1;
    mon_en   = 1'b1;

    // 1: reset
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rst_sig_tx", sig_tx, 1);
    check_eq("rst_ready_tx", ready_tx, 1);
    check_eq("rst_valid_rx", valid_rx, 0);
    check_eq("rst_data_rx", data_rx, 0);

    // 2: single frame, valid held for 3 clocks
    tx_q.push_back(25'h15234A5);
    valid_tx = 1'b1;
    data_tx  = 25'h15234A5;
    @(negedge clk);
    check_eq("t2_ready_fall", ready_tx, 0);
    check_eq("t2_start_bit", sig_tx, 0);
    n = 0;
    while (ready_tx !== 1'b1 && n < TIMEOUT) begin
      n++;
      if (n == 3) begin
        valid_tx = 1'b0;
        data_tx  = '0;
      end
      @(negedge clk);
    end
    check_eq("t2_frame_len", n, FRAME);
    repeat (2 * BIT) @(negedge clk);
    check_eq("t2_one_frame", tx_frames, 1);
    check_eq("t2_idle_ready", ready_tx, 1);

    // 3: loopback of two words with ready_rx low
    loop_en = 1'b1;
    send_word(25'h15234A5, 1'b1);
    send_word(25'h15234DD, 1'b1);
    wait_rx(2);
    check_eq("t3_valid", valid_rx, 1);

    // 4: one-clock ready_rx pulse consumes the word
    ready_rx = 1'b1;
    @(negedge clk);
    ready_rx = 1'b0;
    check_eq("t4_valid_clr", valid_rx, 0);
    check_eq("t4_data_kept", data_rx, 25'h15234DD);

    // 5: false start, then a frame with a low stop bit, then a good frame
    loop_en = 1'b0;
    rx_drv  = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_eq("t5_false_valid", valid_rx, 0);
    drive_frame(25'h0123456, 1'b0, BIT / 2 + 4);
    repeat (3 * BIT) @(negedge clk);
    check_eq("t5_ferr_valid", valid_rx, 0);
    check_eq("t5_ferr_data", data_rx, 25'h15234DD);
    loop_en = 1'b1;
    send_word(25'h0ABCDEF, 1'b1);
    wait_rx(3);

    // 6: valid_tx pulse while busy must be ignored
    send_word(25'h1C0FFEE, 1'b1);
    repeat (100) @(negedge clk);
    check_eq("t6_busy", ready_tx, 0);
    valid_tx = 1'b1;
    data_tx  = 25'h0000001;
    @(negedge clk);
    valid_tx = 1'b0;
    data_tx  = '0;
    wait_rx(4);
    wait_ready();
    repeat (2 * BIT) @(negedge clk);
    check_eq("t6_frames", tx_frames, 5);
    check_eq("t6_idle_line", sig_tx, 1);

    // 7: reset mid-frame aborts transmission and clears the receive side
    mon_en  = 1'b0;
    loop_en = 1'b0;
    valid_tx = 1'b1;
    data_tx  = 25'h0F0F0F0;
    @(negedge clk);
    valid_tx = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("t7_busy", ready_tx, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("t7_sig_tx", sig_tx, 1);
    check_eq("t7_ready_tx", ready_tx, 1);
    check_eq("t7_valid_rx", valid_rx, 0);
    check_eq("t7_data_rx", data_rx, 0);
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t7_quiet", sig_tx, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
